mix_columns: RTL and testbench

MIX_COLUMNS -- requirements
Module: mix_columns

---
 rtl/mix_columns.sv | 152 +++++++++++++++
 tb/tb_mix_columns.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns.sv
// AES MixColumns / InvMixColumns engine: one column per cycle through a single
// shared GF(2^8) constant-multiplier column, framed by an IDLE/MIX/OUTPUT FSM.
module mix_columns #(
  parameter bit INVERSE = 1'b0
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         start,
  input  logic [127:0] block_in,
  output logic [127:0] result_out,
  output logic         valid_out,
  output logic         busy_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MIX    = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t         r_state;
  logic [2:0]     r_col;
  logic [127:0]   r_block;
  logic [127:0]   r_acc;
  logic [31:0]    w_col_in;
  logic [31:0]    w_col_out;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] mul2(input logic [7:0] x);
    return xtime(x);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] x);
    return xtime(x) ^ x;
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ x;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] x);
    return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
  endfunction

  // Column word packs row r of the column into bits [8r +: 8].
  function automatic logic [31:0] mix_fwd(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[7:0];
    a1 = col[15:8];
    a2 = col[23:16];
    a3 = col[31:24];
    return {mul3(a0) ^ a1 ^ a2 ^ mul2(a3),
            a0 ^ a1 ^ mul2(a2) ^ mul3(a3),
            a0 ^ mul2(a1) ^ mul3(a2) ^ a3,
            mul2(a0) ^ mul3(a1) ^ a2 ^ a3};
  endfunction

  function automatic logic [31:0] mix_inv(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[7:0];
    a1 = col[15:8];
    a2 = col[23:16];
    a3 = col[31:24];
    return {mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3),
            muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
            mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
            mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3)};
  endfunction

  // Gather the column currently addressed by the counter from the captured block.
  always_comb begin
    w_col_in = 32'h0;
    for (int r = 0; r < 4; r++) begin
      w_col_in[8*r +: 8] = r_block[32*r + 8*r_col[1:0] +: 8];
    end
  end

  // The one shared column multiplier, fixed to the direction chosen at elaboration.
  always_comb begin
    if (INVERSE) begin
      w_col_out = mix_inv(w_col_in);
    end else begin
      w_col_out = mix_fwd(w_col_in);
    end
  end

  // Control FSM plus capture, accumulate and output registers.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state    <= IDLE;
      r_col      <= 3'd0;
      r_block    <= 128'h0;
      r_acc      <= 128'h0;
      result_out <= 128'h0;
      valid_out  <= 1'b0;
      busy_out   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          valid_out <= 1'b0;
          if (start) begin
            r_block  <= block_in;
            r_col    <= 3'd0;
            r_state  <= MIX;
            busy_out <= 1'b1;
          end else begin
            busy_out <= 1'b0;
          end
        end
        MIX: begin
          busy_out <= 1'b1;
          // Count value 4 is the extra cycle that publishes the finished accumulator.
          if (r_col == 3'd4) begin
            result_out <= r_acc;
            valid_out  <= 1'b1;
            r_col      <= 3'd0;
            r_state    <= OUTPUT;
          end else begin
            for (int r = 0; r < 4; r++) begin
              r_acc[32*r + 8*r_col[1:0] +: 8] <= w_col_out[8*r +: 8];
            end
            valid_out <= 1'b0;
            r_col     <= r_col + 3'd1;
          end
        end
        OUTPUT: begin
          valid_out <= 1'b0;
          busy_out  <= 1'b0;
          r_state   <= IDLE;
        end
        default: begin
          valid_out <= 1'b0;
          busy_out  <= 1'b0;
          r_col     <= 3'd0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns.sv
// Randomised self-checking bench: forward and inverse instances compared every
// cycle against a shift-and-add GF(2^8) matrix model, plus literal vectors.
module tb_mix_columns;

  logic         clk = 1'b0;
  logic         rst_in;
  logic         start_f, start_i;
  logic [127:0] blk_f, blk_i;
  logic [127:0] res_f, res_i;
  logic         val_f, val_i, busy_f, busy_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mix_columns #(.INVERSE(1'b0)) dut_f (
    .clk_in(clk), .rst_in(rst_in), .start(start_f), .block_in(blk_f),
    .result_out(res_f), .valid_out(val_f), .busy_out(busy_f));

  mix_columns #(.INVERSE(1'b1)) dut_i (
    .clk_in(clk), .rst_in(rst_in), .start(start_i), .block_in(blk_i),
    .result_out(res_i), .valid_out(val_i), .busy_out(busy_i));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 30) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = (aa << 1) ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Matrix product: out(r,c) = XOR_k coef[(k-r) mod 4] * in(k,c).
  function automatic logic [127:0] model_mix(input logic [127:0] blk, input bit inv);
    logic [7:0] coef [4];
    logic [7:0] acc;
    logic [127:0] o;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    o = 128'h0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) acc ^= gmul(coef[(k - r + 4) % 4], blk[32*k + 8*c +: 8]);
        o[32*r + 8*c +: 8] = acc;
      end
    return o;
  endfunction

  // Column words written as {row0,row1,row2,row3}.
  function automatic logic [127:0] mk(input logic [31:0] c0, input logic [31:0] c1,
                                      input logic [31:0] c2, input logic [31:0] c3);
    logic [31:0] cw [4];
    logic [127:0] b;
    cw[0] = c0; cw[1] = c1; cw[2] = c2; cw[3] = c3;
    b = 128'h0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[32*r + 8*c +: 8] = cw[c][31 - 8*r -: 8];
    return b;
  endfunction

  // Timing model: accept at edge N when allowed, result at N+5, busy N..N+5, next accept N+7.
  int           cyc = 0;
  bit           armed = 1'b0;
  int           due [2] = '{-1, -1};
  int           busy_until [2] = '{0, 0};
  int           next_accept [2] = '{0, 0};
  logic [127:0] pend [2];
  logic [127:0] exp_res [2] = '{128'h0, 128'h0};

  always @(posedge clk) begin
    logic s;
    logic [127:0] b;
    cyc++;
    if (!rst_in) armed = 1'b1;
    for (int d = 0; d < 2; d++) begin
      s = (d == 0) ? start_f : start_i;
      b = (d == 0) ? blk_f : blk_i;
      if (!rst_in) begin
        due[d] = -1; busy_until[d] = 0; next_accept[d] = 0; exp_res[d] = 128'h0;
      end else begin
        if (cyc == due[d]) exp_res[d] = pend[d];
        if (s && cyc >= next_accept[d]) begin
          pend[d] = model_mix(b, d == 1);
          due[d] = cyc + 5;
          busy_until[d] = cyc + 6;
          next_accept[d] = cyc + 7;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("valid_f", {127'h0, val_f}, {127'h0, cyc == due[0]});
      chk("busy_f", {127'h0, busy_f}, {127'h0, cyc < busy_until[0]});
      chk("result_f", res_f, exp_res[0]);
      chk("valid_i", {127'h0, val_i}, {127'h0, cyc == due[1]});
      chk("busy_i", {127'h0, busy_i}, {127'h0, cyc < busy_until[1]});
      chk("result_i", res_i, exp_res[1]);
    end
  end

  task automatic pulse(input int d, input logic [127:0] b);
    @(negedge clk);
    if (d == 0) begin start_f = 1'b1; blk_f = b; end
    else begin start_i = 1'b1; blk_i = b; end
    @(negedge clk);
    start_f = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic wait_valid(input int d, output logic [127:0] r, output int lat);
    lat = 0;
    r = 128'h0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if ((d == 0 && val_f) || (d == 1 && val_i)) begin
        lat = k;
        r = (d == 0) ? res_f : res_i;
        break;
      end
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] v28_in, v28_out, v29_in, v29_out, v33_in, v33_out, r, r2, x, y;
    int lat, pulses;

    v28_in  = mk(32'hdb135345, 32'hdb135345, 32'hdb135345, 32'hdb135345);
    v28_out = mk(32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc);
    v29_in  = mk(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'h2d26314c);
    v29_out = mk(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'h4d7ebdf8);
    v33_in  = mk(32'hc6c6c6c6, 32'hd4d4d4d5, 32'hc6c6c6c6, 32'hd4d4d4d5);
    v33_out = mk(32'hc6c6c6c6, 32'hd5d5d7d6, 32'hc6c6c6c6, 32'hd5d5d7d6);

    chk("model_fwd_v28", model_mix(v28_in, 1'b0), v28_out);
    chk("model_fwd_v29", model_mix(v29_in, 1'b0), v29_out);
    chk("model_inv_v29", model_mix(v29_out, 1'b1), v29_in);
    chk("model_fwd_v33", model_mix(v33_in, 1'b0), v33_out);

    rst_in = 1'b0; start_f = 1'b0; start_i = 1'b0; blk_f = 128'h0; blk_i = 128'h0;
    repeat (3) @(negedge clk);
    chk("reset_result", res_f, 128'h0);
    chk("reset_valid_busy", {126'h0, val_f, busy_f}, 128'h0);
    rst_in = 1'b1;

    pulse(0, v28_in);
    wait_valid(0, r, lat);
    chk("v28_latency", lat, 5);
    chk("v28_result", r, v28_out);
    @(negedge clk);
    chk("v28_valid_one_cycle", {127'h0, val_f}, 128'h0);

    pulse(0, v29_in);
    wait_valid(0, r, lat);
    chk("v29_result", r, v29_out);
    pulse(0, v33_in);
    wait_valid(0, r, lat);
    chk("v33_result", r, v33_out);
    pulse(1, v29_out);
    wait_valid(1, r, lat);
    chk("inv_v29_latency", lat, 5);
    chk("inv_v29_result", r, v29_in);

    // Extra starts at N+2 and N+5 must be ignored; N+7 is accepted.
    repeat (2) @(negedge clk);
    x = rnd128();
    y = rnd128();
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (val_f) begin
        pulses++;
        if (pulses == 1) chk("ignore_first_result", res_f, model_mix(x, 1'b0));
        if (pulses == 2) chk("accept_n7_result", res_f, model_mix(y, 1'b0));
      end
      start_f = (k == 0 || k == 2 || k == 5 || k == 7);
      blk_f = (k == 0) ? x : (k == 7) ? y : rnd128();
    end
    chk("ignore_pulse_count", pulses, 2);
    start_f = 1'b0;
    repeat (8) @(negedge clk);

    // Abort with reset at N+3, restart at N+5.
    x = rnd128();
    y = rnd128();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 4) chk("abort_state", {res_f[125:0], val_f, busy_f}, 128'h0);
      if (k == 11) begin
        chk("restart_valid", {127'h0, val_f}, 128'h1);
        chk("restart_result", res_f, model_mix(y, 1'b0));
      end
      rst_in = (k != 3);
      start_f = (k == 0 || k == 5);
      blk_f = (k == 0) ? x : (k == 5) ? y : rnd128();
    end
    rst_in = 1'b1;
    start_f = 1'b0;
    repeat (8) @(negedge clk);

    // Forward-then-inverse chain.
    for (int i = 0; i < 1000; i++) begin
      x = rnd128();
      pulse(0, x);
      wait_valid(0, r, lat);
      chk("chain_fwd_latency", lat, 5);
      pulse(1, r);
      wait_valid(1, r2, lat);
      chk("chain_inv_latency", lat, 5);
      chk("chain_roundtrip", r2, x);
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
